// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 master bridge.
//   state_e      : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   PPROT_*      : APB4 PPROT bit meanings (privileged, non-secure, instruction)
//   STRB_NONE    : strobe value driven on reads
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage

// File: rtl/apb4_watchdog.sv
// Transfer watchdog for the APB4 master bridge.
// Counts stalled ACCESS cycles and pulses expire for one cycle when the
// TIMEOUT-th stalled cycle is reached. TIMEOUT = 0 disables it entirely.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (start of a new transfer)
//   enable     : a stalled ACCESS cycle (pready low)
//   expire     : this stalled cycle is the last one allowed
module apb4_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, clear, enable};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + CW'(1);
        end
      end

      // Only meaningful while stalled; a ready slave in the same cycle wins.
      assign expire = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 requester.
// Accepts one command on the cmd_* stream, runs it as an APB4 SETUP/ACCESS
// transfer and returns the completion on the rsp_* stream. A watchdog turns
// a transfer that never sees pready into an error response.
//
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid and ready are both high; a producer holding valid keeps its payload
// stable until that edge, and ready never depends on valid.
//
// Ports:
//   pclk, presetn               : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_write/addr/wdata/strb/prot : command payload
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata/err/timeout       : response payload (registered)
//   psel..pprot                 : APB4 requester outputs
//   pready/prdata/pslverr       : APB4 completer inputs
//   dbg_state                   : current FSM state for observation
module apb4_master_bridge
  import apb4_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  input  logic [2:0]           cmd_prot,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  output logic [2:0]           pprot,
  input  logic                 pready,
  input  logic [31:0]          prdata,
  input  logic                 pslverr,
  output state_e               dbg_state
);

  state_e state;
  state_e state_next;

  logic accept;
  logic wd_enable;
  logic wd_expire;
  logic access_done;

  assign accept      = cmd_valid && cmd_ready;
  assign wd_enable   = (state == ST_ACCESS) && !pready;
  assign access_done = (state == ST_ACCESS) && (pready || wd_expire);
  assign dbg_state   = state;

  apb4_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (pclk),
    .rst_n  (presetn),
    .clear  (accept),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // psel/penable decode straight from the state flop so that reset removes
  // them immediately without waiting for a clock.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        psel       = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || wd_expire) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transfer attributes load once per command and then hold, both through
  // the transfer and afterwards until the next command.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= STRB_NONE;
      pprot  <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
      pstrb  <= cmd_write ? cmd_strb : STRB_NONE;
      pprot  <= cmd_prot;
    end
  end

  // Response payload is written only when ACCESS ends. pready takes
  // priority over the watchdog in the expiry cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (access_done) begin
      rsp_valid <= 1'b1;
      if (pready) begin
        rsp_rdata   <= pwrite ? 32'h0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else begin
        rsp_rdata   <= 32'h0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
